// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-aligned PC generation, credit-limited
// memory requests, 2-entry instruction buffer and redirect handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  discard_q, discard_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [31:0] buf_data_q [2];
    logic [31:0] buf_data_d [2];
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];

    logic [2:0]  used;
    logic        req_fire;
    logic        rsp_ok;
    logic        push;
    logic        pop;
    logic        wr_idx;
    logic [31:0] target_pc;

    // Credits cover both outstanding requests and buffered words, so a
    // returning response always has a free slot. Reset gates the request.
    assign used           = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req_valid = rst & enable & ~redirect_valid
                          & (used < 3'(MAX_INFLIGHT));
    assign imem_req_addr  = fetch_pc_q;

    assign instr_valid = (count_q != 2'd0);
    assign instruction = instr_valid ? buf_data_q[head_q] : 32'h0;
    assign instr_pc    = instr_valid ? buf_pc_q[head_q] : 32'h0;

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign rsp_ok    = imem_rsp_valid & (inflight_q != 2'd0);
    assign pop       = instr_valid & instr_ready;
    assign push      = rsp_ok & (discard_q == 2'd0) & ~redirect_valid;
    assign wr_idx    = head_q ^ count_q[0];
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    // Next-state: PC advance, credit tracking, stale-response discard and FIFO.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        discard_d  = discard_q;
        count_d    = count_q;
        head_d     = head_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        inflight_d = inflight_q + {1'b0, req_fire} - {1'b0, rsp_ok};

        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            discard_d  = inflight_q - {1'b0, rsp_ok};
            count_d    = 2'd0;
            head_d     = 1'b0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_ok && discard_q != 2'd0) begin
                discard_d = discard_q - 2'd1;
            end
            if (push) begin
                buf_data_d[wr_idx] = imem_rsp_data;
                buf_pc_d[wr_idx]   = rsp_pc_q;
                rsp_pc_d           = rsp_pc_q + 32'd4;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                head_d = ~head_q;
            end
        end
    end

    // State registers; reset drops all in-flight and buffered state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= START_PC;
            rsp_pc_q   <= START_PC;
            inflight_q <= 2'd0;
            discard_q  <= 2'd0;
            count_q    <= 2'd0;
            head_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= 32'h0;
                buf_pc_q[i]   <= 32'h0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            head_q     <= head_d;
            buf_data_q <= buf_data_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based transaction model
// with an in-order variable-latency instruction memory.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'hFFFF_FFFA;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .MAX_INFLIGHT(2)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instruction(instruction),
        .instr_pc(instr_pc)
    );

    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    req_t        mq[$];
    ent_t        bq[$];
    mem_t        mem[$];
    logic [31:0] m_pc;
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          errs;
    int          checks;

    logic [31:0] tgt_tab [6] = '{32'h103, 32'h0, 32'hFFFF_FFFE,
                                 32'h8000_0001, 32'hFFFF_FFF4, 32'h40};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        mq.delete();
        bq.delete();
        mem.delete();
        m_pc = RPC & 32'hFFFF_FFFC;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
    endtask

    task automatic step(bit en, bit rdy, bit redir, logic [31:0] rpc, bit ir);
        bit   exp_rv;
        bit   exp_iv;
        bit   fire;
        bit   got_rsp;
        req_t r;
        int   due;
        @(negedge clk);
        enable = en;
        imem_req_ready = rdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        instr_ready = ir;
        if (mem.size() > 0 && mem[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mem_word(mem[0].addr);
        end else if (mem.size() == 0 && $urandom_range(15) == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = $urandom;
        end
        #1;
        exp_rv = en && !redir && (mq.size() + bq.size() < 2);
        exp_iv = bq.size() != 0;
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_iv});
        check("instruction", instruction, exp_iv ? bq[0].data : 32'h0);
        check("instr_pc", instr_pc, exp_iv ? bq[0].pc : 32'h0);

        fire = exp_rv && rdy;
        got_rsp = imem_rsp_valid && mq.size() > 0;
        if (got_rsp) void'(mem.pop_front());
        if (redir) begin
            if (got_rsp) void'(mq.pop_front());
            foreach (mq[i]) mq[i].stale = 1'b1;
            bq.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (exp_iv && ir) void'(bq.pop_front());
            if (got_rsp) begin
                r = mq.pop_front();
                if (!r.stale) bq.push_back('{r.pc, imem_rsp_data});
            end
            if (fire) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (mem.size() > 0 && due <= mem[$].due) due = mem[$].due + 1;
                mq.push_back('{m_pc, 1'b0});
                mem.push_back('{m_pc, due});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        errs = 0;
        checks = 0;
        cyc = 0;
        lat_min = 1;
        lat_max = 1;
        rst = 1'b0;
        enable = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        do_reset();

        // Streaming with 1-cycle memory across the address wrap.
        repeat (30) step(1, 1, 0, 32'h0, 1);

        // Stalled consumer fills the buffer, then drains.
        repeat (10) step(1, 1, 0, 32'h0, 0);
        repeat (10) step(1, 1, 0, 32'h0, 1);

        // Redirect with slow memory and requests in flight.
        lat_min = 3;
        lat_max = 3;
        repeat (4) step(1, 1, 0, 32'h0, 1);
        step(1, 1, 1, 32'h103, 1);
        repeat (20) step(1, 1, 0, 32'h0, 1);

        // Randomized traffic with periodic mid-run resets.
        lat_min = 1;
        lat_max = 3;
        for (int n = 0; n < 1600; n++) begin
            logic [31:0] t;
            if (n % 400 == 399) do_reset();
            t = ($urandom_range(1) == 0) ? tgt_tab[$urandom_range(5)] : $urandom;
            step($urandom_range(7) != 0, $urandom_range(3) != 0,
                 $urandom_range(11) == 0, t, $urandom_range(3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
